// File: rtl/frame_stats_pkg.sv
// rtl/frame_stats_pkg.sv - shared types and widths for the frame statistics collector
package frame_stats_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IDX_W  = 6;
  localparam int FRAME_LEN  = 2 ** DEF_IDX_W;
  localparam int SUM_W      = DEF_DATA_W + DEF_IDX_W;
  localparam int CNT_W      = DEF_IDX_W + 1;

  typedef enum logic {
    SYNC,
    ACCUM
  } state_t;

  typedef enum logic [2:0] {
    HOLD,
    STEP,
    WRAP,
    START0,
    JUMP
  } edge_t;

endpackage

// File: rtl/frame_stats_out_reg.sv
// rtl/frame_stats_out_reg.sv - valid/ready holding register with drop-on-busy and sticky overrun
module frame_stats_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         offer,
  input  logic [W-1:0] offer_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         overrun
);

  logic load;

  // A new item is accepted when the register is empty or is being drained on this edge
  assign load = offer && (!valid || ready);

  // Hold the item until drained; an offer that cannot be taken is dropped and flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      data    <= '0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        data  <= offer_data;
      end else if (ready) begin
        valid <= 1'b0;
      end
      if (offer && !load) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_stats_collector.sv
// rtl/frame_stats_collector.sv - per-frame sum/min/max/count over a wrapping sample index
module frame_stats_collector
  import frame_stats_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [IDX_W-1:0]          IDX,
  input  logic [DATA_W-1:0]         SAMPLE,
  input  logic                      SAMPLE_VALID,
  output logic [DATA_W+IDX_W-1:0]   STAT_SUM,
  output logic [DATA_W-1:0]         STAT_MIN,
  output logic [DATA_W-1:0]         STAT_MAX,
  output logic [IDX_W:0]            STAT_COUNT,
  output logic                      STAT_VALID,
  input  logic                      STAT_READY,
  output logic                      FRAME_ABORT,
  output logic                      OVERRUN
);

  localparam int SUM_BITS = DATA_W + IDX_W;
  localparam int CNT_BITS = IDX_W + 1;
  localparam int PAY_W    = SUM_BITS + 2 * DATA_W + CNT_BITS;

  state_t              state, state_nxt;
  edge_t               edge_cls;
  logic [IDX_W-1:0]    prev_idx;
  logic [IDX_W-1:0]    idx_inc;

  logic [SUM_BITS-1:0] acc_sum, sum_nxt, init_sum;
  logic [DATA_W-1:0]   acc_min, min_nxt, init_min;
  logic [DATA_W-1:0]   acc_max, max_nxt, init_max;
  logic [CNT_BITS-1:0] acc_cnt, cnt_nxt, init_cnt;

  logic                offer;
  logic                abort_nxt;
  logic [DATA_W-1:0]   offer_min;
  logic [PAY_W-1:0]    stat_data;

  assign idx_inc = prev_idx + 1'b1;

  // A frame starts from the sample seen on its index-0 edge
  assign init_sum = SAMPLE_VALID ? SUM_BITS'(SAMPLE) : '0;
  assign init_min = SAMPLE_VALID ? SAMPLE : '1;
  assign init_max = SAMPLE_VALID ? SAMPLE : '0;
  assign init_cnt = SAMPLE_VALID ? CNT_BITS'(1) : '0;

  // An empty frame reports min as zero rather than the all-ones seed
  assign offer_min = (acc_cnt == '0) ? '0 : acc_min;

  // Classify how the index moved relative to the previous cycle
  always_comb begin
    edge_cls = JUMP;
    if (state != SYNC && IDX == prev_idx) begin
      edge_cls = HOLD;
    end else if (IDX != '0 && IDX == idx_inc) begin
      edge_cls = STEP;
    end else if (IDX == '0 && prev_idx == '1) begin
      edge_cls = WRAP;
    end else if (IDX == '0) begin
      edge_cls = START0;
    end
  end

  // Next-state and accumulator update for the sync/accumulate FSM
  always_comb begin
    state_nxt = state;
    sum_nxt   = acc_sum;
    min_nxt   = acc_min;
    max_nxt   = acc_max;
    cnt_nxt   = acc_cnt;
    offer     = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      SYNC: begin
        if (IDX == '0) begin
          state_nxt = ACCUM;
          sum_nxt   = init_sum;
          min_nxt   = init_min;
          max_nxt   = init_max;
          cnt_nxt   = init_cnt;
        end
      end
      ACCUM: begin
        case (edge_cls)
          HOLD: ;
          STEP: begin
            if (SAMPLE_VALID) begin
              sum_nxt = acc_sum + SUM_BITS'(SAMPLE);
              cnt_nxt = acc_cnt + 1'b1;
              min_nxt = (SAMPLE < acc_min) ? SAMPLE : acc_min;
              max_nxt = (SAMPLE > acc_max) ? SAMPLE : acc_max;
            end
          end
          WRAP, START0: begin
            offer     = (edge_cls == WRAP);
            abort_nxt = (edge_cls == START0);
            sum_nxt   = init_sum;
            min_nxt   = init_min;
            max_nxt   = init_max;
            cnt_nxt   = init_cnt;
          end
          JUMP: begin
            abort_nxt = 1'b1;
            state_nxt = SYNC;
            sum_nxt   = '0;
            min_nxt   = '1;
            max_nxt   = '0;
            cnt_nxt   = '0;
          end
          default: ;
        endcase
      end
      default: state_nxt = SYNC;
    endcase
  end

  // State, previous index, accumulators and the registered abort pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= SYNC;
      prev_idx    <= '0;
      acc_sum     <= '0;
      acc_min     <= '1;
      acc_max     <= '0;
      acc_cnt     <= '0;
      FRAME_ABORT <= 1'b0;
    end else begin
      state       <= state_nxt;
      prev_idx    <= IDX;
      acc_sum     <= sum_nxt;
      acc_min     <= min_nxt;
      acc_max     <= max_nxt;
      acc_cnt     <= cnt_nxt;
      FRAME_ABORT <= abort_nxt;
    end
  end

  frame_stats_out_reg #(
    .W(PAY_W)
  ) u_out_reg (
    .clk       (CLK),
    .rst       (RST),
    .offer     (offer),
    .offer_data({acc_sum, offer_min, acc_max, acc_cnt}),
    .ready     (STAT_READY),
    .valid     (STAT_VALID),
    .data      (stat_data),
    .overrun   (OVERRUN)
  );

  assign {STAT_SUM, STAT_MIN, STAT_MAX, STAT_COUNT} = stat_data;

endmodule

// File: doc/frame_stats_collector.md
Name: frame_stats_collector

Overview:
- Consumes the 6-bit wrapping index from the free-running counter, together with a per-cycle gesture sensor sample.
- Treats each full 0..63 index sweep as one frame and accumulates sum, min, max and valid-sample count for that frame.
- Presents one frame summary per frame to the downstream classifier over a valid/ready handshake.
- Detects index discontinuities (counter reset mid-sweep) and discards the affected frame.

Parameters:
- DATA_W, 8, sample width in bits (unsigned).
- IDX_W, 6, index width in bits; frame length is 2**IDX_W.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IDX  in  IDX_W  counter output (sample index).
- SAMPLE  in  DATA_W  sensor sample.
- SAMPLE_VALID  in  1  SAMPLE is meaningful this cycle.
- STAT_SUM  out  DATA_W+IDX_W  sum of accepted samples in frame.
- STAT_MIN  out  DATA_W  minimum accepted sample.
- STAT_MAX  out  DATA_W  maximum accepted sample.
- STAT_COUNT  out  IDX_W+1  number of accepted samples (0..64).
- STAT_VALID  out  1  summary held and valid.
- STAT_READY  in  1  downstream accepts summary.
- FRAME_ABORT  out  1  one-cycle pulse: frame discarded on discontinuity.
- OVERRUN  out  1  sticky: completed frame dropped because output still held.

Behaviour:
- RST asserted: state=SYNC, PREV_IDX=0, accumulators cleared (sum=0, cnt=0, min=all-ones, max=0), all outputs 0, OVERRUN=0.
- PREV_IDX <= IDX every cycle.
- Edge classes, evaluated on each rising edge:
  - HOLD: IDX==PREV_IDX, and state is not SYNC.
  - STEP: IDX==PREV_IDX+1, IDX!=0.
  - WRAP: IDX==0 and PREV_IDX==all-ones.
  - START0: IDX==0, otherwise.
  - JUMP: anything else.
- SYNC:
  - IDX==0 → ACCUM; accumulators initialised from the current sample (cnt=1, sum=min=max=SAMPLE if SAMPLE_VALID, else cleared).
  - Any other IDX → stay in SYNC.
- ACCUM on STEP: if SAMPLE_VALID, sum+=SAMPLE, cnt+=1, min/max updated.
- ACCUM on HOLD: no change; the sample is ignored (no double counting).
- ACCUM on WRAP:
  - The completed frame's stats (excluding the current sample) are offered to the output register.
  - Accumulators are re-initialised from the current sample as in SYNC→ACCUM.
  - State stays ACCUM.
- ACCUM on START0 (counter reset mid-frame): FRAME_ABORT pulses for one cycle, nothing is emitted, accumulators are re-initialised from the current sample, state stays ACCUM.
- ACCUM on JUMP: FRAME_ABORT pulses, accumulators are cleared, state=SYNC.
- Output register:
  - Loads when offered if STAT_VALID==0, or if STAT_VALID&&STAT_READY in the same cycle.
  - Otherwise the offered frame is dropped and OVERRUN is set; OVERRUN is cleared only by RST.
  - STAT_VALID rises the cycle after the WRAP edge (latency 1).
  - STAT_VALID falls after an edge with STAT_READY=1, unless reloaded on that same edge.
  - Outputs are stable while STAT_VALID=1 and STAT_READY=0.
- Empty frame (cnt=0) is still emitted, with STAT_MIN=0, STAT_MAX=0, STAT_SUM=0.
- Width: STAT_SUM max is 64*255=16320 < 2**14, so no overflow and no saturation logic.
- RST mid-operation: immediate clear per the first bullet; a pending summary is lost.

Decomposition:
- Package frame_stats_pkg holds:
  - state enum {SYNC, ACCUM};
  - localparams FRAME_LEN, SUM_W=DATA_W+IDX_W, CNT_W=IDX_W+1;
  - edge-class enum {HOLD, STEP, WRAP, START0, JUMP}.
- One sub-module, frame_stats_out_reg: a valid/ready holding register with load/drop/overrun logic, reusable for other summary streams.

Test Plan:
- Reset, then IDX sweeps 0..63 with SAMPLE=IDX and SAMPLE_VALID=1, STAT_READY=1 → on IDX=0 wrap, next cycle STAT_VALID=1, SUM=2016, MIN=0, MAX=63, COUNT=64.
- SAMPLE_VALID=1 only on IDX 10..19 with SAMPLE=200 → SUM=2000, MIN=200, MAX=200, COUNT=10.
- SAMPLE_VALID=0 for a whole frame → STAT_VALID pulse with SUM=0, MIN=0, MAX=0, COUNT=0.
- Counter reset to 0 at IDX=40 → FRAME_ABORT one-cycle pulse, no STAT_VALID, next full sweep reports COUNT=64.
- IDX jumps 20→45 → FRAME_ABORT, state SYNC, no summary until after the next IDX=0 start plus a full sweep.
- STAT_READY held 0 across two frame completions → first summary held stable, second dropped, OVERRUN=1; after STAT_READY=1, STAT_VALID drops; OVERRUN stays 1 until RST.
